// File: rtl/exotiny_pkg.sv
// Shared types and defaults for the ExoTiny memory-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exotiny_pkg;

  // Arbiter FSM states; the fixed encoding keeps older netlists compatible.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  // Bus masters competing for the single QSPI controller port.
  typedef enum logic {
    M_IMEM = 1'b0,
    M_DMEM = 1'b1
  } arb_master_t;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 1023;

endpackage

// File: rtl/exotiny_arb_wdog.sv
// Per-transaction watchdog: counts stalled granted cycles, flags terminal count.
// Latency: tc_o is combinational on the cycle the count would reach TIMEOUT.
// Backpressure: none; it only observes, clears itself on terminal count or clr_i.
module exotiny_arb_wdog
  import exotiny_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT,
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic [TO_W-1:0] load_val_i,
  input  logic            inc_i,
  output logic            tc_o
);

  // TIMEOUT stalled cycles have elapsed when the count sits at TIMEOUT-1 and increments again.
  localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign tc_o = inc_i && (cnt_q == TC_VAL);

  // Next count: clear wins over load, load wins over increment; wrap to zero on terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/exotiny_mem_arb.sv
// Round-robin Wishbone arbiter: imem/dmem masters onto one QSPI memory port, with watchdog abort.
// Latency: grant one cycle after request in IDLE; slave ack/data forwarded combinationally.
// Backpressure: the losing master simply sees no ack and keeps its request pending.
module exotiny_mem_arb
  import exotiny_pkg::*;
#(
  parameter int unsigned ADR_W   = 32,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             imem_stb_i,
  input  logic [ADR_W-1:0] imem_adr_i,
  output logic [31:0]      imem_dat_o,
  output logic             imem_ack_o,
  input  logic             dmem_cyc_i,
  input  logic             dmem_stb_i,
  input  logic             dmem_we_i,
  input  logic [3:0]       dmem_be_i,
  input  logic [ADR_W-1:0] dmem_adr_i,
  input  logic [31:0]      dmem_dat_i,
  output logic [31:0]      dmem_dat_o,
  output logic             dmem_ack_o,
  output logic             mem_cyc_o,
  output logic             mem_stb_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [ADR_W-1:0] mem_adr_o,
  output logic [31:0]      mem_dat_o,
  input  logic [31:0]      mem_dat_i,
  input  logic             mem_ack_i,
  output logic             to_flag_o,
  input  logic             to_clr_i
);

  arb_state_t  state_q, state_d;
  arb_master_t last_q, last_d;
  logic        to_flag_q, to_flag_d;

  logic        req_i, req_d;
  logic        gnt_i, gnt_d, granted, in_abort;
  logic        gnt_req;
  arb_master_t gnt_m;
  logic        wd_inc, wd_clr, wd_tc;

  assign req_i    = imem_stb_i;
  assign req_d    = dmem_cyc_i & dmem_stb_i;
  assign gnt_i    = (state_q == GNT_I);
  assign gnt_d    = (state_q == GNT_D);
  assign granted  = gnt_i | gnt_d;
  assign in_abort = (state_q == ABORT);
  assign gnt_m    = gnt_d ? M_DMEM : M_IMEM;
  // Request of whichever master holds the grant (don't-care outside GNT_x).
  assign gnt_req  = gnt_d ? req_d : req_i;

  // Only a granted, still-requesting, un-acked cycle counts as stalled.
  assign wd_inc = granted & gnt_req & ~mem_ack_i;
  assign wd_clr = ~wd_inc;

  exotiny_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (wd_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (wd_inc),
    .tc_o       (wd_tc)
  );

  // Arbitration, completion/abandon and watchdog abort; timeout set beats software clear.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    to_flag_d = to_flag_q & ~to_clr_i;
    case (state_q)
      IDLE: begin
        if (req_i && req_d) begin
          state_d = (last_q == M_IMEM) ? GNT_D : GNT_I;
        end else if (req_i) begin
          state_d = GNT_I;
        end else if (req_d) begin
          state_d = GNT_D;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ack_i || !gnt_req) begin
          state_d = IDLE;
          last_d  = gnt_m;
        end else if (wd_tc) begin
          state_d   = ABORT;
          last_d    = gnt_m;
          to_flag_d = 1'b1;
        end
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any grant at the next edge and favours dmem on the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_q    <= M_IMEM;
      to_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      to_flag_q <= to_flag_d;
    end
  end

  // Slave side: granted master's request muxed through, everything zero otherwise.
  assign mem_cyc_o = granted;
  assign mem_stb_o = granted;
  assign mem_we_o  = gnt_d & dmem_we_i;
  assign mem_be_o  = gnt_d ? dmem_be_i  : (gnt_i ? 4'hF : 4'h0);
  assign mem_adr_o = gnt_d ? dmem_adr_i : (gnt_i ? imem_adr_i : '0);
  assign mem_dat_o = gnt_d ? dmem_dat_i : 32'h0;

  // Master side: ack only to the grant holder; ABORT acks the master just served (last_q) with zero data.
  assign imem_ack_o = (gnt_i & mem_ack_i) | (in_abort & (last_q == M_IMEM));
  assign dmem_ack_o = (gnt_d & mem_ack_i) | (in_abort & (last_q == M_DMEM));
  assign imem_dat_o = in_abort ? 32'h0 : mem_dat_i;
  assign dmem_dat_o = in_abort ? 32'h0 : mem_dat_i;
  assign to_flag_o  = to_flag_q;

endmodule

// File: doc/exotiny_mem_arb.md
Name: exotiny_mem_arb

Overview:
- Arbitrates the single ExoTiny QSPI memory controller port between the FazyRV instruction bus (imem) and data bus (dmem).
- Wishbone-classic on all three sides; instantiated inside exotiny between core and QSPI controller.
- Round-robin on simultaneous requests, per-transaction watchdog that terminates hung slave accesses, sticky timeout status for the SoC.

Parameters:
- ADR_W, 32, address width on all ports.
- TIMEOUT, 1023, max cycles a granted transaction may wait for slave ack; range 1..65535.
- TO_W, $clog2(TIMEOUT+1), derived watchdog counter width (localparam).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- imem_stb_i  in  1  instruction request (read only).
- imem_adr_i  in  ADR_W  instruction address.
- imem_dat_o  out  32  instruction read data.
- imem_ack_o  out  1  instruction ack.
- dmem_cyc_i  in  1  data cycle.
- dmem_stb_i  in  1  data strobe.
- dmem_we_i  in  1  data write enable.
- dmem_be_i  in  4  data byte enables.
- dmem_adr_i  in  ADR_W  data address.
- dmem_dat_i  in  32  data write data.
- dmem_dat_o  out  32  data read data.
- dmem_ack_o  out  1  data ack.
- mem_cyc_o  out  1  slave cycle.
- mem_stb_o  out  1  slave strobe.
- mem_we_o  out  1  slave write enable.
- mem_be_o  out  4  slave byte enables.
- mem_adr_o  out  ADR_W  slave address.
- mem_dat_o  out  32  slave write data.
- mem_dat_i  in  32  slave read data.
- mem_ack_i  in  1  slave ack.
- to_flag_o  out  1  sticky: at least one timeout occurred.
- to_clr_i  in  1  clears to_flag_o.

Behaviour:
- States: IDLE, GNT_I, GNT_D, ABORT. Reset (sync, rst_i=1 at posedge) -> IDLE, last_served=IMEM, watchdog=0, to_flag_o=0; reset mid-transaction drops the grant immediately.
- Request definition: req_i=imem_stb_i; req_d=dmem_cyc_i&dmem_stb_i.
- IDLE: only req_i -> GNT_I; only req_d -> GNT_D; both -> grant the master not in last_served (first tie after reset goes to DMEM); none -> stay.
- Arbitration latency: 1 cycle (request seen in IDLE, slave strobed from next cycle).
- GNT_x: mem_cyc_o=mem_stb_o=1. Granted master's adr/we/be/dat are muxed combinationally to the slave. Imem grant drives we=0, be=4'hF, dat=0.
- mem_ack_i is forwarded combinationally to the granted master's ack; mem_dat_i goes to both dat_o outputs.
- mem_ack_i=1 in GNT_x -> IDLE, last_served=x, watchdog cleared.
- Granted master drops its request before ack -> IDLE without ack, last_served=x; slave sees cyc/stb low next cycle.
- Watchdog counts each GNT_x cycle without ack. It reaches TIMEOUT -> ABORT, to_flag_o<=1.
- ABORT (1 cycle): mem_cyc_o=mem_stb_o=0; acks granted master with dat_o=32'h0; then IDLE, last_served=x.
- Non-granted master: ack=0 and its request stays pending. No starvation: the other master is guaranteed the next grant after each completed transaction.
- mem_ack_i in IDLE or ABORT is ignored and never forwarded.
- Outputs in IDLE/ABORT: mem_* all 0, both acks 0 (except the ABORT ack).
- to_flag_o: set beats clear when timeout and to_clr_i coincide.
- Minimum throughput: one transaction per (slave latency+1) cycles; back-to-back from one master always passes through IDLE.

Decomposition:
- Shared package exotiny_pkg: enum arb_state_t {IDLE,GNT_I,GNT_D,ABORT}; enum arb_master_t {M_IMEM,M_DMEM}; constant ARB_TIMEOUT_DEFAULT=1023.
- One sub-module, exotiny_arb_wdog: loadable/clearable counter with terminal-count output, parameterized by TIMEOUT.

Test Plan:
- Reset, then imem_stb_i=1 adr=32'h0000_0100, slave acks 3 cycles after stb with dat 32'hDEAD_BEEF -> mem_stb_o rises 1 cycle after request, imem_ack_o=1 with imem_dat_o=32'hDEAD_BEEF, dmem_ack_o=0 throughout.
- Both requesting in the same cycle right after reset -> DMEM granted first (mem_adr_o=dmem_adr_i, we/be/dat passed), then IMEM. With both held continuously, grants strictly alternate D,I,D,I over 8 transactions.
- dmem write we=1 be=4'b0011 dat=32'h1234_5678 -> mem_we_o=1, mem_be_o=4'b0011, mem_dat_o=32'h1234_5678 while granted; imem_stb_i asserted mid-transaction gets no ack until after dmem_ack_o.
- TIMEOUT=8, slave never acks an imem request -> mem_cyc_o drops after 8 granted cycles, imem_ack_o=1 with dat 0 in ABORT, to_flag_o=1. to_clr_i pulse -> 0. Timeout coinciding with to_clr_i -> stays 1.
- rst_i asserted during GNT_D with a pending slave ack -> next cycle mem_cyc_o=0, no acks, state IDLE. A stray mem_ack_i in IDLE is not forwarded.
- dmem drops cyc/stb 2 cycles into its grant -> IDLE without dmem_ack_o, and a pending imem is granted next.
